// File: rtl/digest_pkg.sv
// digest_pkg: op encodings, IV constants and word/state types shared by digest_state_bank.
package digest_pkg;
    typedef logic [31:0] word_t;
    typedef word_t [7:0] state_t;
    localparam logic [1:0] OP_INIT  = 2'b00;
    localparam logic [1:0] OP_ACCUM = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;
    localparam state_t SHA256_IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam state_t SHA224_IV = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
    // Word-wise modular add; carries never cross a word boundary.
    function automatic state_t word_add(input state_t a, input state_t b);
        state_t r;
        for (int i = 0; i < 8; i++) r[i] = a[i] + b[i];
        return r;
    endfunction
endpackage

// File: rtl/digest_out_serializer.sv
// digest_out_serializer: holds a READ snapshot and drains it MS beat first over a valid/ready handshake.
module digest_out_serializer
    import digest_pkg::*;
#(
    parameter int OUT_W = 32,
    parameter int CTX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  state_t           load_data,
    input  logic [CTX_W-1:0] load_ctx,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [CTX_W-1:0] out_ctx,
    output logic             done
);
    localparam int BEATS = 256 / OUT_W;
    localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    logic [255:0]     snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic [CTX_W-1:0] ctx_q, ctx_d;
    logic             acc;
    assign out_valid = vld_q;
    assign out_data  = snap_q[255 -: OUT_W];
    assign out_last  = vld_q && cnt_q == CNT_W'(BEATS - 1);
    assign out_ctx   = ctx_q;
    // The snapshot shifts left per accepted beat so the current beat is always the top slice.
    always_comb begin
        acc    = vld_q && out_ready;
        done   = acc && out_last;
        vld_d  = load ? 1'b1 : done ? 1'b0 : vld_q;
        cnt_d  = load ? '0 : acc ? cnt_q + 1'b1 : cnt_q;
        snap_d = load ? load_data : acc ? snap_q << OUT_W : snap_q;
        ctx_d  = load ? load_ctx : ctx_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
            ctx_q  <= '0;
        end else begin
            snap_q <= snap_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            ctx_q  <= ctx_d;
        end
    end
endmodule

// File: rtl/digest_state_bank.sv
// digest_state_bank: NUM_CTX 256-bit digest contexts with INIT/ACCUM/LOAD/READ commands and beat readout.
// Optional SHA-224 INIT variant and H7 masking enabled by defining DIGEST_SHA224_EN.
module digest_state_bank
    import digest_pkg::*;
#(
    parameter int NUM_CTX = 4,
    parameter int OUT_W = 32,
    localparam int CTX_W = $clog2(NUM_CTX) > 1 ? $clog2(NUM_CTX) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [CTX_W-1:0]   cmd_ctx,
    input  logic [255:0]       cmd_data,
    input  logic               cmd_sha224,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    output logic [CTX_W-1:0]   out_ctx,
    output logic [NUM_CTX-1:0] ctx_valid,
    output logic               err
);
    localparam logic [0:0] IDLE = 1'b0, DRAIN = 1'b1;
    state_t             ctx_q [NUM_CTX];
    state_t             ctx_d [NUM_CTX];
    logic [NUM_CTX-1:0] vld_q, vld_d, match;
    logic [0:0]         st_q, st_d;
    logic               err_q, err_d;
    logic               fire, ctx_ok, cur_vld, rd_go, done;
    state_t             cur, snap, iv;
`ifdef DIGEST_SHA224_EN
    logic [NUM_CTX-1:0] is224_q, is224_d;
    logic               cur224;
`else
    logic               sha_unused;
    assign sha_unused = cmd_sha224;
`endif
    assign cmd_ready = st_q == IDLE;
    assign ctx_valid = vld_q;
    assign err       = err_q;
    always_comb begin
        fire    = cmd_valid && cmd_ready;
        cur     = '0;
        cur_vld = 1'b0;
`ifdef DIGEST_SHA224_EN
        cur224  = 1'b0;
        iv      = cmd_sha224 ? SHA224_IV : SHA256_IV;
        is224_d = is224_q;
`else
        iv      = SHA256_IV;
`endif
        for (int i = 0; i < NUM_CTX; i++) begin
            match[i] = cmd_ctx == CTX_W'(i);
            if (match[i]) begin
                cur     = ctx_q[i];
                cur_vld = vld_q[i];
`ifdef DIGEST_SHA224_EN
                cur224  = is224_q[i];
`endif
            end
            ctx_d[i] = !(fire && match[i]) ? ctx_q[i] :
                       cmd_op == OP_INIT ? iv :
                       cmd_op == OP_LOAD ? state_t'(cmd_data) :
                       (cmd_op == OP_ACCUM && vld_q[i]) ? word_add(ctx_q[i], state_t'(cmd_data)) : ctx_q[i];
            vld_d[i] = vld_q[i] | (fire && match[i] && (cmd_op == OP_INIT || cmd_op == OP_LOAD));
`ifdef DIGEST_SHA224_EN
            if (fire && match[i] && cmd_op == OP_INIT) is224_d[i] = cmd_sha224;
            if (fire && match[i] && cmd_op == OP_LOAD) is224_d[i] = 1'b0;
`endif
        end
        // Out-of-range indices match nothing, so they fall out as "no valid context".
        ctx_ok = |match;
        rd_go  = fire && cmd_op == OP_READ && cur_vld;
        snap   = cur;
`ifdef DIGEST_SHA224_EN
        if (cur224) snap[0] = '0;
`endif
        err_d  = fire && ((cmd_op == OP_ACCUM || cmd_op == OP_READ) ? !cur_vld : !ctx_ok);
        st_d   = rd_go ? DRAIN : (st_q == DRAIN && done) ? IDLE : st_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CTX; i++) ctx_q[i] <= '0;
            vld_q <= '0;
            st_q  <= IDLE;
            err_q <= 1'b0;
`ifdef DIGEST_SHA224_EN
            is224_q <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CTX; i++) ctx_q[i] <= ctx_d[i];
            vld_q <= vld_d;
            st_q  <= st_d;
            err_q <= err_d;
`ifdef DIGEST_SHA224_EN
            is224_q <= is224_d;
`endif
        end
    end
    digest_out_serializer #(.OUT_W(OUT_W), .CTX_W(CTX_W)) u_ser (
        .clk(clk),
        .reset(reset),
        .load(rd_go),
        .load_data(snap),
        .load_ctx(cmd_ctx),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_last(out_last),
        .out_ctx(out_ctx),
        .done(done)
    );
endmodule

// File: tb/tb_digest_state_bank.sv
// tb_digest_state_bank: random and directed stimulus checked every cycle against a word-level context model.
module tb_digest_state_bank;
    localparam int NUM_CTX = 4;
    localparam int OUT_W = 32;
    localparam int CTX_W = 2;
    logic               clk = 0, reset = 0;
    logic               cmd_valid = 0, cmd_sha224 = 0, out_ready = 1;
    logic [1:0]         cmd_op = 0;
    logic [CTX_W-1:0]   cmd_ctx = 0;
    logic [255:0]       cmd_data = 0;
    logic               cmd_ready, out_valid, out_last, err;
    logic [OUT_W-1:0]   out_data;
    logic [CTX_W-1:0]   out_ctx;
    logic [NUM_CTX-1:0] ctx_valid;
    int checks = 0, errors = 0;
    bit chk_en = 0;
    logic [31:0] iv256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [31:0] iv224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                               32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    logic [31:0]        m_st [NUM_CTX][8];
    logic [NUM_CTX-1:0] m_vld, m_224;
    logic [31:0]        m_q [$];
    logic               m_err;
    logic [CTX_W-1:0]   m_octx;
    logic [31:0]        got [8];

    digest_state_bank #(.NUM_CTX(NUM_CTX), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ctx(cmd_ctx), .cmd_data(cmd_data), .cmd_sha224(cmd_sha224), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .out_ctx(out_ctx),
        .ctx_valid(ctx_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contexts as arrays of eight words, a READ becomes a queue of beats.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CTX; c++) for (int w = 0; w < 8; w++) m_st[c][w] = 0;
            m_vld = 0; m_224 = 0; m_err = 0; m_octx = 0;
            m_q.delete();
        end else begin
            int c;
            bit ok, sha;
            m_err = 0;
            c = int'(cmd_ctx);
            ok = c < NUM_CTX;
`ifdef DIGEST_SHA224_EN
            sha = cmd_sha224;
`else
            sha = 0;
`endif
            if (m_q.size() != 0) begin
                if (out_ready) void'(m_q.pop_front());
            end else if (cmd_valid) begin
                if (cmd_op == 2'b00) begin
                    if (ok) begin
                        for (int w = 0; w < 8; w++) m_st[c][w] = sha ? iv224[w] : iv256[w];
                        m_vld[c] = 1; m_224[c] = sha;
                    end else m_err = 1;
                end else if (cmd_op == 2'b10) begin
                    if (ok) begin
                        for (int w = 0; w < 8; w++) m_st[c][w] = cmd_data[255 - 32*w -: 32];
                        m_vld[c] = 1; m_224[c] = 0;
                    end else m_err = 1;
                end else if (cmd_op == 2'b01) begin
                    if (ok && m_vld[c]) begin
                        for (int w = 0; w < 8; w++) m_st[c][w] = m_st[c][w] + cmd_data[255 - 32*w -: 32];
                    end else m_err = 1;
                end else begin
                    if (ok && m_vld[c]) begin
                        for (int w = 0; w < 8; w++) m_q.push_back((w == 7 && m_224[c]) ? 32'h0 : m_st[c][w]);
                        m_octx = cmd_ctx;
                    end else m_err = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("cmd_ready", cmd_ready, m_q.size() == 0);
            chk("out_valid", out_valid, m_q.size() != 0);
            chk("out_last", out_last, m_q.size() == 1);
            chk("err", err, m_err);
            chk("ctx_valid", ctx_valid, m_vld);
            if (m_q.size() != 0) begin
                chk("out_data", out_data, m_q[0]);
                chk("out_ctx", out_ctx, m_octx);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [CTX_W-1:0] ctx, input logic [255:0] data, input logic sha);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_wait", cmd_ready, 1);
        cmd_valid = 1; cmd_op = op; cmd_ctx = ctx; cmd_data = data; cmd_sha224 = sha;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic read_ctx(input logic [CTX_W-1:0] ctx, input int stall_at, output logic [31:0] beats [8]);
        logic [31:0] held;
        send(2'b11, ctx, '0, 0);
        for (int b = 0; b < 8; b++) begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("read_valid_wait", out_valid, 1);
            if (b == stall_at) begin
                out_ready = 0;
                held = out_data;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_data_hold", out_data, held);
                    chk("stall_valid_hold", out_valid, 1);
                    chk("stall_cmd_ready", cmd_ready, 0);
                end
                out_ready = 1;
            end
            beats[b] = out_data;
            chk("read_out_ctx", out_ctx, ctx);
            chk("read_out_last", out_last, b == 7);
            @(negedge clk);
        end
        chk("read_end_valid", out_valid, 0);
    endtask

    initial begin
        logic [255:0] k;
        #1 reset = 1;
        #1 chk("rst_out_valid_async", out_valid, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        chk_en = 1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_ctx", out_ctx, 0);
        chk("rst_err", err, 0);
        chk("rst_ctx_valid", ctx_valid, 0);
        @(negedge clk);
        send(2'b00, 0, '0, 0);
        read_ctx(0, -1, got);
        for (int b = 0; b < 8; b++) chk("init_iv256", got[b], iv256[b]);
        send(2'b10, 1, {8{32'hffffffff}}, 0);
        send(2'b01, 1, {8{32'h00000001}}, 0);
        read_ctx(1, -1, got);
        for (int b = 0; b < 8; b++) chk("accum_wrap", got[b], 32'h0);
        k = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        send(2'b10, 2, k, 0);
        read_ctx(2, 1, got);
        for (int b = 0; b < 8; b++) chk("load_stall_read", got[b], k[255 - 32*b -: 32]);
        send(2'b01, 3, {8{32'h12345678}}, 0);
        chk("uninit_err_pulse", err, 1);
        @(negedge clk);
        chk("uninit_err_clear", err, 0);
        chk("uninit_ctx_valid3", ctx_valid[3], 0);
        chk("uninit_out_valid", out_valid, 0);
        for (int i = 0; i < 1500; i++) begin
            out_ready = $urandom_range(0, 3) != 0;
            cmd_valid = $urandom_range(0, 2) == 0;
            cmd_op = 2'($urandom);
            cmd_ctx = CTX_W'($urandom);
            for (int w = 0; w < 8; w++)
                cmd_data[255 - 32*w -: 32] = $urandom_range(0, 3) == 0 ? 32'hffffffff - $urandom_range(0, 3) : $urandom;
            cmd_sha224 = 1'($urandom);
            @(negedge clk);
        end
        cmd_valid = 0;
        out_ready = 1;
        repeat (20) @(negedge clk);
        send(2'b00, 0, '0, 0);
        send(2'b11, 0, '0, 0);
        repeat (3) @(negedge clk);
        chk("pre_abort_valid", out_valid, 1);
        reset = 1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_ctx_valid", ctx_valid, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_no_beats", out_valid, 0);
`ifdef DIGEST_SHA224_EN
        send(2'b00, 0, '0, 1);
        read_ctx(0, -1, got);
        for (int b = 0; b < 7; b++) chk("init_iv224", got[b], iv224[b]);
        chk("sha224_h7_zero", got[7], 32'h0);
`endif
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
